mips_instr_encoder: RTL and testbench

Instruction encoder and loader for the single-cycle MIPS core: the inverse of the control decoder. It accepts symbolic instructions (mnemonic index plus register and immediate fields) over a valid/ready stream and encodes each into a 32-bit MIPS word. It writes the words into instruction memory at consecutive word addresses through a registered valid/ready write port. Testbenches and the boot loader use it to build programs for the core.

---
 rtl/mips_enc_pkg.sv | 68 ++++++
 rtl/mips_enc_core.sv | 28 ++
 rtl/mips_instr_encoder.sv | 93 +++++++++
 tb/tb_mips_instr_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_enc_pkg.sv
// Shared types for the MIPS instruction encoder: mnemonic indices, opcode/funct
// codes, the loader FSM state and the symbolic-instruction request struct.
package mips_enc_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
    OP_OR   = 5'd4,  OP_SLT  = 5'd5,  OP_SRL  = 5'd6,  OP_XOR  = 5'd7,
    OP_LW   = 5'd8,  OP_SW   = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11,
    OP_J    = 5'd12, OP_JAL  = 5'd13, OP_ADDI = 5'd14, OP_ANDI = 5'd15,
    OP_ORI  = 5'd16, OP_XORI = 5'd17, OP_SLTI = 5'd18, OP_LUI  = 5'd19,
    OP_JR   = 5'd20
  } mnem_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_LW   = 6'h23, OPC_SW   = 6'h2B,
                         OPC_BEQ   = 6'h04, OPC_BNE  = 6'h05, OPC_J    = 6'h02,
                         OPC_JAL   = 6'h03, OPC_ADDI = 6'h08, OPC_ANDI = 6'h0C,
                         OPC_ORI   = 6'h0D, OPC_XORI = 6'h0E, OPC_SLTI = 6'h0A,
                         OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_SLT = 6'h2A, FN_SRL = 6'h02, FN_XOR = 6'h26, FN_JR = 6'h08;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FULL} state_e;

  // op is kept as raw bits so illegal indices 21..31 remain representable
  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } enc_req_t;

  function automatic logic [5:0] funct_of(input logic [4:0] op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_SLT:  return FN_SLT;
      OP_SRL:  return FN_SRL;
      OP_XOR:  return FN_XOR;
      OP_JR:   return FN_JR;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input logic [4:0] op);
    case (op)
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_BEQ:  return OPC_BEQ;
      OP_BNE:  return OPC_BNE;
      OP_J:    return OPC_J;
      OP_JAL:  return OPC_JAL;
      OP_ADDI: return OPC_ADDI;
      OP_ANDI: return OPC_ANDI;
      OP_ORI:  return OPC_ORI;
      OP_XORI: return OPC_XORI;
      OP_SLTI: return OPC_SLTI;
      OP_LUI:  return OPC_LUI;
      default: return OPC_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/mips_enc_core.sv
// Combinational encoder: symbolic instruction -> 32-bit MIPS word plus an
// illegal-op flag (illegal indices produce an all-zero word).
module mips_enc_core
  import mips_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.op)
      OP_NOP: word = '0;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_XOR:
        word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'd0, funct_of(req.op)};
      OP_SRL: word = {OPC_RTYPE, 5'd0, req.rt, req.rd, req.shamt, FN_SRL};
      OP_JR:  word = {OPC_RTYPE, req.rs, 10'd0, 5'd0, FN_JR};
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
        word = {opcode_of(req.op), req.rs, req.rt, req.imm};
      OP_LUI: word = {OPC_LUI, 5'd0, req.rt, req.imm};
      OP_J, OP_JAL: word = {opcode_of(req.op), req.target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes a stream of symbolic instructions and writes them to
// consecutive instruction-memory words. Optional ENC_CHECK_EN drops illegal ops and flags err.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic [AW:0]   wr_count,
  output logic          err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_op,
  input  logic [4:0]    s_rs,
  input  logic [4:0]    s_rt,
  input  logic [4:0]    s_rd,
  input  logic [4:0]    s_shamt,
  input  logic [15:0]   s_imm,
  input  logic [25:0]   s_target,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_data
);

`ifdef ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e      state;
  logic [AW:0] acc_cnt, wr_cnt;
  logic        err_q;
  enc_req_t    req;
  logic [31:0] word;
  logic        illegal, drop, acc, wr;

  assign req = '{op: s_op, rs: s_rs, rt: s_rt, rd: s_rd, shamt: s_shamt,
                 imm: s_imm, target: s_target};

  mips_enc_core u_core (.req(req), .word(word), .illegal(illegal));

  assign drop    = CHECK_EN && illegal;
  assign s_ready = (state == ST_RUN) && (!m_valid || m_ready) && (acc_cnt < DEPTH_C);
  // start wins over any handshake offered in the same cycle
  assign acc     = s_valid && s_ready && !start;
  assign wr      = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      state   <= ST_RUN;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      m_valid <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr) wr_cnt <= wr_cnt + 1'b1;
      // a new word reloads the register in the same cycle the old one drains
      if (acc && !drop) begin
        m_valid <= 1'b1;
        m_data  <= word;
        acc_cnt <= acc_cnt + 1'b1;
      end else if (wr) begin
        m_valid <= 1'b0;
      end
      if (acc && drop) err_q <= 1'b1;
      case (state)
        ST_RUN:   if (acc && !drop && acc_cnt == DEPTH_C - 1'b1) state <= ST_DRAIN;
        ST_DRAIN: if (wr) state <= ST_FULL;
        default:  ;
      endcase
    end
  end

  assign m_addr   = wr_cnt[AW-1:0];
  assign wr_count = wr_cnt;
  assign done     = (state == ST_FULL);
  assign err      = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized
// streams checked against an arithmetic encoding model.
module tb_mips_instr_encoder;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
`ifdef ENC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [4:0]  s_op = '0, s_rs = '0, s_rt = '0, s_rd = '0, s_shamt = '0;
  logic [15:0] s_imm = '0;
  logic [25:0] s_target = '0;
  logic        s_ready, done, err, m_valid;
  logic [AW:0] wr_count;
  logic [AW-1:0] m_addr;
  logic [31:0] m_data;

  int n_chk = 0, n_fail = 0;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         got[$];
  logic [31:0] expq[$];

  // funct / opcode per mnemonic index 0..20
  longint rfn[21]  = '{0, 32, 34, 36, 37, 42, 2, 38, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8};
  longint iopc[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 35, 43, 4, 5, 2, 3, 8, 12, 13, 14, 10, 15, 0};

  always #5 clk = ~clk;

  mips_instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .wr_count(wr_count), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_rs(s_rs), .s_rt(s_rt), .s_rd(s_rd),
    .s_shamt(s_shamt), .s_imm(s_imm), .s_target(s_target),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data)
  );

  always @(negedge clk)
    if (rst_n && !start && m_valid && m_ready) got.push_back('{int'(m_addr), m_data});

  function automatic logic [31:0] ref_word(input longint op, rs, rt, rd, sh, imm, tgt);
    if (op == 0 || op > 20) return 32'h0;
    if (op <= 7 || op == 20) begin
      if (op == 6) rs = 0; else sh = 0;
      if (op == 20) begin rt = 0; rd = 0; end
      return 32'(rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 2**6 + rfn[op]);
    end
    if (op == 12 || op == 13) return 32'(iopc[op] * 2**26 + tgt);
    if (op == 19) rs = 0;
    return 32'(iopc[op] * 2**26 + rs * 2**21 + rt * 2**16 + imm);
  endfunction

  function automatic logic [31:0] cur_ref();
    return ref_word(s_op, s_rs, s_rt, s_rd, s_shamt, s_imm, s_target);
  endfunction

  task automatic step(); @(posedge clk); #1; endtask
  task automatic settle(); @(negedge clk); endtask

  task automatic set_in(input int op, rs, rt, rd, sh, imm, tgt);
    s_op = 5'(op); s_rs = 5'(rs); s_rt = 5'(rt); s_rd = 5'(rd); s_shamt = 5'(sh);
    s_imm = 16'(imm); s_target = 26'(tgt);
  endtask

  task automatic rand_in(input int lo, input int hi);
    set_in(int'($urandom_range(hi, lo)), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic do_start();
    s_valid = 1'b0; start = 1'b1;
    got.delete(); expq.delete();
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({s_ready, m_valid, done, err, m_addr, wr_count, m_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b mv=%b done=%b err=%b addr=%0d cnt=%0d data=%h, exp all 0",
               s_ready, m_valid, done, err, m_addr, wr_count, m_data);
    end
    step(); rst_n = 1'b1; step();
    s_valid = 1'b1; settle();
    n_chk++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_sready: got %b exp 0", s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_add();
    do_start();
    m_ready = 1'b0; set_in(1, 1, 2, 3, 0, 0, 0); s_valid = 1'b1;
    settle();
    n_chk++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL add_sready: got %b exp 1", s_ready); end
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h00221820 || m_addr !== 0) begin
      n_fail++; $display("FAIL add_word: got v=%b addr=%0d data=%h exp v=1 addr=0 data=00221820", m_valid, m_addr, m_data);
    end
    m_ready = 1'b1; step(); settle();
    n_chk++;
    if (wr_count !== 1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_written: got cnt=%0d v=%b exp cnt=1 v=0", wr_count, m_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    m_ready = 1'b1; set_in(8, 29, 8, 0, 0, 16'h0004, 0); s_valid = 1'b1;
    step(); set_in(12, 0, 0, 0, 0, 0, 26'h0100000); settle();
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h8FA80004 || m_addr !== 0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_lw: got v=%b addr=%0d data=%h rdy=%b exp v=1 addr=0 data=8fa80004 rdy=1",
                         m_valid, m_addr, m_data, s_ready);
    end
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 32'h08100000 || m_addr !== 1) begin
      n_fail++; $display("FAIL b2b_j: got v=%b addr=%0d data=%h exp v=1 addr=1 data=08100000", m_valid, m_addr, m_data);
    end
    step(); settle();
    n_chk++;
    if (wr_count !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d exp 2", wr_count); end
  endtask

  task automatic test_srl();
    logic [31:0] e;
    do_start();
    m_ready = 1'b1; set_in(6, 7, 5, 4, 2, 0, 0); s_valid = 1'b1;
    step(); set_in(1, $urandom, $urandom, $urandom, 3, 0, 0); e = cur_ref(); settle();
    n_chk++;
    if (m_data !== 32'h00052082) begin n_fail++; $display("FAIL srl_word: got %h exp 00052082", m_data); end
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_data !== e || m_data[10:6] !== 5'd0) begin
      n_fail++; $display("FAIL add_shamt0: got %h exp %h", m_data, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    do_start();
    m_ready = 1'b0; rand_in(1, 20); a = cur_ref(); s_valid = 1'b1;
    step(); rand_in(1, 20); b = cur_ref();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_chk++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== a || m_addr !== 0) begin
        n_fail++; $display("FAIL bp_hold: got rdy=%b v=%b addr=%0d data=%h exp rdy=0 v=1 addr=0 data=%h",
                           s_ready, m_valid, m_addr, m_data, a);
      end
      step();
    end
    m_ready = 1'b1; settle();
    n_chk++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b exp 1", s_ready); end
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_data !== b || m_addr !== 1 || wr_count !== 1) begin
      n_fail++; $display("FAIL bp_next: got addr=%0d cnt=%0d data=%h exp addr=1 cnt=1 data=%h", m_addr, wr_count, m_data, b);
    end
  endtask

  task automatic test_full();
    int acc = 0;
    bit last, prev_last = 1'b0;
    do_start();
    m_ready = 1'b1; rand_in(1, 20); s_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      n_chk++;
      if (s_ready && acc >= DEPTH) begin n_fail++; $display("FAIL full_overaccept: got rdy=1 after %0d accepts, exp 0", acc); end
      if (prev_last) begin
        n_chk++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_rise: got %b exp 1", done); end
      end
      last = m_valid && m_ready && (m_addr == AW'(DEPTH - 1));
      if (last) begin
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b exp 0", done); end
      end
      prev_last = last;
      if (s_valid && s_ready) begin expq.push_back(cur_ref()); acc++; end
      step();
      rand_in(1, 20);
    end
    s_valid = 1'b0; settle();
    n_chk++;
    if (got.size() != DEPTH || wr_count !== DEPTH || done !== 1'b1 || acc != DEPTH) begin
      n_fail++; $display("FAIL full_status: got writes=%0d cnt=%0d done=%b acc=%0d exp %0d/%0d/1/%0d",
                         got.size(), wr_count, done, acc, DEPTH, DEPTH, DEPTH);
    end
    foreach (got[i]) begin
      n_chk++;
      if (i >= expq.size() || got[i].addr != i || got[i].data !== expq[i]) begin
        n_fail++; $display("FAIL full_word%0d: got addr=%0d data=%h exp addr=%0d", i, got[i].addr, got[i].data, i);
      end
    end
  endtask

  task automatic test_start_mid();
    logic [31:0] w;
    do_start();
    m_ready = 1'b1; rand_in(1, 20); s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); rand_in(1, 20); end
    m_ready = 1'b0; s_valid = 1'b0; settle();
    n_chk++;
    if (wr_count !== 2 || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending: got cnt=%0d v=%b exp cnt=2 v=1", wr_count, m_valid);
    end
    do_start(); settle();
    n_chk++;
    if (m_valid !== 1'b0 || wr_count !== 0 || m_addr !== 0) begin
      n_fail++; $display("FAIL mid_cleared: got v=%b cnt=%0d addr=%0d exp 0/0/0", m_valid, wr_count, m_addr);
    end
    m_ready = 1'b1; rand_in(1, 20); w = cur_ref(); s_valid = 1'b1;
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_valid !== 1'b1 || m_addr !== 0 || m_data !== w) begin
      n_fail++; $display("FAIL mid_restart: got v=%b addr=%0d data=%h exp v=1 addr=0 data=%h", m_valid, m_addr, m_data, w);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    do_start();
    m_ready = 1'b1; set_in(25, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom); s_valid = 1'b1;
    settle();
    n_chk++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ill_sready: got %b exp 1", s_ready); end
    step(); s_valid = 1'b0; settle();
`ifdef ENC_CHECK_EN
    n_chk++;
    if (m_valid !== 1'b0 || err !== 1'b1 || m_addr !== 0) begin
      n_fail++; $display("FAIL ill_drop: got v=%b err=%b addr=%0d exp v=0 err=1 addr=0", m_valid, err, m_addr);
    end
    rand_in(1, 20); w = cur_ref(); s_valid = 1'b1;
    step(); s_valid = 1'b0; settle();
    n_chk++;
    if (m_addr !== 0 || m_data !== w || err !== 1'b1) begin
      n_fail++; $display("FAIL ill_next: got addr=%0d data=%h err=%b exp addr=0 data=%h err=1", m_addr, m_data, err, w);
    end
    do_start(); settle();
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear: got %b exp 0", err); end
`else
    w = 32'h0;
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== w || err !== 1'b0 || m_addr !== 0) begin
      n_fail++; $display("FAIL ill_nop: got v=%b data=%h err=%b addr=%0d exp v=1 data=0 err=0 addr=0",
                         m_valid, m_data, err, m_addr);
    end
    step(); settle();
    n_chk++;
    if (wr_count !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL ill_written: got cnt=%0d err=%b exp 1/0", wr_count, err);
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int acc = 0;
      bit ill = 1'b0, fin = 1'b0;
      do_start();
      for (int c = 0; c < 80 && !fin; c++) begin
        s_valid = 1'($urandom_range(1, 0));
        m_ready = ($urandom_range(3, 0) != 0);
        rand_in(0, 31);
        settle();
        n_chk++;
        if (s_ready && acc >= DEPTH) begin n_fail++; $display("FAIL rnd_overaccept: got rdy=1 after %0d, exp 0", acc); end
        if (s_valid && s_ready) begin
          if (CHECK && s_op > 20) ill = 1'b1;
          else begin expq.push_back(cur_ref()); acc++; end
        end
        step();
        if (done) fin = 1'b1;
      end
      s_valid = 1'b0; settle();
      n_chk++;
      if (!fin || got.size() != DEPTH || err !== ill) begin
        n_fail++; $display("FAIL rnd_round%0d: got done=%b writes=%0d err=%b exp done=1 writes=%0d err=%b",
                           r, fin, got.size(), err, DEPTH, ill);
      end
      foreach (got[i]) begin
        n_chk++;
        if (i >= expq.size() || got[i].addr != i || got[i].data !== expq[i]) begin
          n_fail++; $display("FAIL rnd_word%0d_%0d: got addr=%0d data=%h", r, i, got[i].addr, got[i].data);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_srl();
    test_backpressure();
    test_full();
    test_start_mid();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
